// File: rtl/sti_rx_if.sv
// Serial input, configuration and parallel output bundle for sti_rx.
// The master side drives serial bits/config and po_ready; the slave side (sti_rx) returns the word.
interface sti_rx_if;
  logic        si_data;
  logic        si_valid;
  logic [1:0]  cfg_length;
  logic        cfg_msb;
  logic        cfg_low;
  logic        cfg_fill;
  logic        po_ready;
  logic [15:0] po_data;
  logic        po_valid;
  logic        po_err;
  logic [7:0]  frame_cnt;

  modport master (
    output si_data, si_valid, cfg_length, cfg_msb, cfg_low, cfg_fill, po_ready,
    input  po_data, po_valid, po_err, frame_cnt
  );

  modport slave (
    input  si_data, si_valid, cfg_length, cfg_msb, cfg_low, cfg_fill, po_ready,
    output po_data, po_valid, po_err, frame_cnt
  );
endinterface

// File: rtl/sti_rx.sv
// Deserialises 8/16/24/32-bit serial frames into a 16-bit word, valid one cycle after the last bit.
// Single-entry output: a frame finishing while the held word is unconsumed is dropped and sets po_err.
module sti_rx (
  input  logic    clk,
  input  logic    reset,
  sti_rx_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] frm_q, frm_d;
  logic [1:0]  len_q, len_d;
  logic        msb_q, msb_d;
  logic        low_q, low_d;
  logic        fill_q, fill_d;
  logic [15:0] po_data_q, po_data_d;
  logic        po_valid_q, po_valid_d;
  logic        po_err_q, po_err_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;

  logic        done;
  logic        abort;
  logic        pad_err;
  logic [15:0] word;

  // Frame always occupies frm[31:32-N]; LSB-first frames start at the bottom of that window.
  function automatic logic [4:0] bit_pos(input logic [4:0] k, input logic [1:0] len, input logic msb);
    if (msb) return 5'd31 - k;
    return 5'd24 - {len, 3'b000} + k;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    frm_d   = frm_q;
    len_d   = len_q;
    msb_d   = msb_q;
    low_d   = low_q;
    fill_d  = fill_q;
    done    = 1'b0;
    abort   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.si_valid) begin
          len_d  = bus.cfg_length;
          msb_d  = bus.cfg_msb;
          low_d  = bus.cfg_low;
          fill_d = bus.cfg_fill;
          frm_d  = '0;
          frm_d[bit_pos(5'd0, bus.cfg_length, bus.cfg_msb)] = bus.si_data;
          cnt_d   = 5'd1;
          state_d = RECV;
        end
      end
      RECV: begin
        if (bus.si_valid) begin
          frm_d[bit_pos(cnt_q, len_q, msb_q)] = bus.si_data;
          if (cnt_q == {len_q, 3'b111}) begin
            done    = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end else begin
          abort   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Extraction looks at frm_d so the word can be registered on the same edge as the last bit.
  always_comb begin
    word    = '0;
    pad_err = 1'b0;
    case (len_q)
      2'd0: word = low_q ? {frm_d[31:24], 8'h00} : {8'h00, frm_d[31:24]};
      2'd1: word = frm_d[31:16];
      2'd2: begin
        word    = fill_q ? frm_d[31:16] : frm_d[23:8];
        pad_err = fill_q ? |frm_d[15:8] : |frm_d[31:24];
      end
      default: begin
        word    = fill_q ? frm_d[31:16] : frm_d[15:0];
        pad_err = fill_q ? |frm_d[15:0] : |frm_d[31:16];
      end
    endcase
  end

  always_comb begin
    po_data_d   = po_data_q;
    po_valid_d  = po_valid_q;
    po_err_d    = po_err_q;
    frame_cnt_d = frame_cnt_q;
    if (po_valid_q && bus.po_ready) po_valid_d = 1'b0;
    if (abort) po_err_d = 1'b1;
    if (done) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
      if (pad_err) po_err_d = 1'b1;
      if (po_valid_q && !bus.po_ready) begin
        po_err_d = 1'b1;
      end else begin
        po_data_d  = word;
        po_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      frm_q       <= '0;
      len_q       <= '0;
      msb_q       <= 1'b0;
      low_q       <= 1'b0;
      fill_q      <= 1'b0;
      po_data_q   <= '0;
      po_valid_q  <= 1'b0;
      po_err_q    <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      frm_q       <= frm_d;
      len_q       <= len_d;
      msb_q       <= msb_d;
      low_q       <= low_d;
      fill_q      <= fill_d;
      po_data_q   <= po_data_d;
      po_valid_q  <= po_valid_d;
      po_err_q    <= po_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign bus.po_data   = po_data_q;
  assign bus.po_valid  = po_valid_q;
  assign bus.po_err    = po_err_q;
  assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_sti_rx.sv
// Bench for sti_rx: directed scenarios plus randomized frames against a transaction-level model.
module tb_sti_rx;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int failures = 0;

  logic [15:0] exp_data = '0;
  logic        exp_valid = 1'b0;
  logic        exp_err = 1'b0;
  logic [7:0]  exp_cnt = '0;

  sti_rx_if bus ();
  sti_rx dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  // Frame value v holds the N frame bits as an integer (bit N-1 is the word MSB).
  // Returns {pad_error, expected po_data}.
  function automatic logic [16:0] model_word(input logic [1:0] len, input logic low,
                                             input logic fill, input logic [31:0] v);
    case (len)
      2'd0:    return {1'b0, (low ? {v[7:0], 8'h00} : {8'h00, v[7:0]})};
      2'd1:    return {1'b0, v[15:0]};
      2'd2:    return fill ? {|v[7:0], v[23:8]} : {|v[23:16], v[15:0]};
      default: return fill ? {|v[15:0], v[31:16]} : {|v[31:16], v[15:0]};
    endcase
  endfunction

  // One clock: update the model with what this cycle does, then advance past the edge.
  task automatic tick(input bit fin, input logic [15:0] w, input bit perr, input bit abrt);
    if (fin) begin
      exp_cnt = exp_cnt + 8'd1;
      if (perr) exp_err = 1'b1;
      if (exp_valid && !bus.po_ready) exp_err = 1'b1;
      else begin
        exp_data  = w;
        exp_valid = 1'b1;
      end
    end else if (exp_valid && bus.po_ready) begin
      exp_valid = 1'b0;
    end
    if (abrt) exp_err = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.si_valid = 1'b0;
    reset = 1'b0;
    #3;
    reset = 1'b1;
    exp_data  = '0;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    exp_cnt   = '0;
    @(posedge clk);
    #1;
  endtask

  // Sends the first nsend bits of a frame; config inputs are scrambled after bit 0.
  task automatic send_frame(input logic [1:0] len, input logic msb, input logic low,
                            input logic fill, input logic [31:0] v, input int nsend, input bit b2b);
    int n;
    logic [16:0] mw;
    n  = (int'(len) + 1) * 8;
    mw = model_word(len, low, fill, v);
    bus.cfg_length = len;
    bus.cfg_msb    = msb;
    bus.cfg_low    = low;
    bus.cfg_fill   = fill;
    for (int k = 0; k < nsend; k++) begin
      bus.si_valid = 1'b1;
      bus.si_data  = msb ? v[n-1-k] : v[k];
      tick(k == n - 1, mw[15:0], mw[16], 1'b0);
      if (k == 0) begin
        bus.cfg_length = 2'($urandom_range(0, 3));
        bus.cfg_msb    = 1'($urandom_range(0, 1));
        bus.cfg_low    = 1'($urandom_range(0, 1));
        bus.cfg_fill   = 1'($urandom_range(0, 1));
      end
    end
    if (!b2b) bus.si_valid = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (bus.po_data !== 16'h0000) begin failures++; $display("FAIL reset_data got=%h want=0000", bus.po_data); end
    checks++; if (bus.po_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", bus.po_valid); end
    checks++; if (bus.po_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", bus.po_err); end
    checks++; if (bus.frame_cnt !== 8'd0) begin failures++; $display("FAIL reset_cnt got=%0d want=0", bus.frame_cnt); end
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_msb8();
    do_reset();
    bus.po_ready = 1'b1;
    send_frame(2'd0, 1'b1, 1'b0, 1'b0, 32'hA5, 7, 1'b1);
    checks++; if (bus.po_valid !== 1'b0) begin failures++; $display("FAIL msb8_early_valid got=%b want=0", bus.po_valid); end
    bus.si_data = 1'b1;
    tick(1'b1, 16'h00A5, 1'b0, 1'b0);
    bus.si_valid = 1'b0;
    checks++; if (bus.po_data !== 16'h00A5) begin failures++; $display("FAIL msb8_data got=%h want=00a5", bus.po_data); end
    checks++; if (bus.po_valid !== 1'b1) begin failures++; $display("FAIL msb8_valid got=%b want=1", bus.po_valid); end
    checks++; if (bus.frame_cnt !== 8'd1) begin failures++; $display("FAIL msb8_cnt got=%0d want=1", bus.frame_cnt); end
    checks++; if (bus.po_err !== 1'b0) begin failures++; $display("FAIL msb8_err got=%b want=0", bus.po_err); end
  endtask

  task automatic test_lsb16();
    do_reset();
    send_frame(2'd1, 1'b0, 1'b0, 1'b0, 32'h1234, 16, 1'b0);
    checks++; if (bus.po_data !== 16'h1234) begin failures++; $display("FAIL lsb16_data got=%h want=1234", bus.po_data); end
    checks++; if (bus.po_valid !== 1'b1) begin failures++; $display("FAIL lsb16_valid got=%b want=1", bus.po_valid); end
    checks++; if (bus.po_err !== 1'b0) begin failures++; $display("FAIL lsb16_err got=%b want=0", bus.po_err); end
  endtask

  task automatic test_pad24();
    do_reset();
    send_frame(2'd2, 1'b1, 1'b0, 1'b0, 32'h0000BEEF, 24, 1'b0);
    checks++; if (bus.po_data !== 16'hBEEF) begin failures++; $display("FAIL pad24_clean_data got=%h want=beef", bus.po_data); end
    checks++; if (bus.po_err !== 1'b0) begin failures++; $display("FAIL pad24_clean_err got=%b want=0", bus.po_err); end
    send_frame(2'd2, 1'b1, 1'b0, 1'b0, 32'h0080BEEF, 24, 1'b0);
    checks++; if (bus.po_data !== 16'hBEEF) begin failures++; $display("FAIL pad24_dirty_data got=%h want=beef", bus.po_data); end
    checks++; if (bus.po_err !== 1'b1) begin failures++; $display("FAIL pad24_dirty_err got=%b want=1", bus.po_err); end
    checks++; if (bus.frame_cnt !== 8'd2) begin failures++; $display("FAIL pad24_cnt got=%0d want=2", bus.frame_cnt); end
  endtask

  task automatic test_overflow();
    do_reset();
    bus.po_ready = 1'b0;
    send_frame(2'd3, 1'b1, 1'b0, 1'b1, 32'hCAFE0000, 32, 1'b1);
    send_frame(2'd3, 1'b1, 1'b0, 1'b1, 32'h12340000, 32, 1'b0);
    checks++; if (bus.po_data !== 16'hCAFE) begin failures++; $display("FAIL ovf_data got=%h want=cafe", bus.po_data); end
    checks++; if (bus.po_valid !== 1'b1) begin failures++; $display("FAIL ovf_valid got=%b want=1", bus.po_valid); end
    checks++; if (bus.po_err !== 1'b1) begin failures++; $display("FAIL ovf_err got=%b want=1", bus.po_err); end
    checks++; if (bus.frame_cnt !== 8'd2) begin failures++; $display("FAIL ovf_cnt got=%0d want=2", bus.frame_cnt); end
    bus.po_ready = 1'b1;
    tick(1'b0, 16'h0, 1'b0, 1'b0);
    checks++; if (bus.po_valid !== 1'b0) begin failures++; $display("FAIL ovf_drain got=%b want=0", bus.po_valid); end
    // Consume and reload on the same edge: no error, valid stays high.
    do_reset();
    bus.po_ready = 1'b0;
    send_frame(2'd0, 1'b1, 1'b0, 1'b0, 32'h3C, 8, 1'b1);
    send_frame(2'd0, 1'b1, 1'b0, 1'b0, 32'h5A, 7, 1'b1);
    bus.po_ready = 1'b1;
    bus.si_data  = 1'b0;
    tick(1'b1, 16'h005A, 1'b0, 1'b0);
    bus.si_valid = 1'b0;
    checks++; if (bus.po_data !== 16'h005A) begin failures++; $display("FAIL swap_data got=%h want=005a", bus.po_data); end
    checks++; if (bus.po_valid !== 1'b1) begin failures++; $display("FAIL swap_valid got=%b want=1", bus.po_valid); end
    checks++; if (bus.po_err !== 1'b0) begin failures++; $display("FAIL swap_err got=%b want=0", bus.po_err); end
  endtask

  task automatic test_abort();
    do_reset();
    bus.po_ready = 1'b1;
    send_frame(2'd1, 1'b1, 1'b0, 1'b0, 32'hFFFF, 5, 1'b1);
    bus.si_valid = 1'b0;
    tick(1'b0, 16'h0, 1'b0, 1'b1);
    checks++; if (bus.po_valid !== 1'b0) begin failures++; $display("FAIL abort_valid got=%b want=0", bus.po_valid); end
    checks++; if (bus.po_err !== 1'b1) begin failures++; $display("FAIL abort_err got=%b want=1", bus.po_err); end
    checks++; if (bus.frame_cnt !== 8'd0) begin failures++; $display("FAIL abort_cnt got=%0d want=0", bus.frame_cnt); end
    send_frame(2'd1, 1'b1, 1'b0, 1'b0, 32'h9876, 16, 1'b0);
    checks++; if (bus.po_data !== 16'h9876) begin failures++; $display("FAIL abort_next_data got=%h want=9876", bus.po_data); end
    checks++; if (bus.frame_cnt !== 8'd1) begin failures++; $display("FAIL abort_next_cnt got=%0d want=1", bus.frame_cnt); end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    bus.po_ready = 1'b0;
    send_frame(2'd0, 1'b1, 1'b0, 1'b0, 32'h77, 8, 1'b0);
    send_frame(2'd3, 1'b1, 1'b0, 1'b0, $urandom, 10, 1'b1);
    bus.si_data = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    checks++; if (bus.po_data !== 16'h0000) begin failures++; $display("FAIL midrst_data got=%h want=0000", bus.po_data); end
    checks++; if (bus.po_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b want=0", bus.po_valid); end
    checks++; if (bus.frame_cnt !== 8'd0) begin failures++; $display("FAIL midrst_cnt got=%0d want=0", bus.frame_cnt); end
    bus.si_valid = 1'b0;
    #2;
    reset = 1'b1;
    exp_data = '0; exp_valid = 1'b0; exp_err = 1'b0; exp_cnt = '0;
    @(posedge clk);
    #1;
    bus.po_ready = 1'b1;
    send_frame(2'd0, 1'b1, 1'b1, 1'b0, 32'hFF, 8, 1'b0);
    checks++; if (bus.po_data !== 16'hFF00) begin failures++; $display("FAIL midrst_next_data got=%h want=ff00", bus.po_data); end
    checks++; if (bus.po_err !== 1'b0) begin failures++; $display("FAIL midrst_next_err got=%b want=0", bus.po_err); end
    checks++; if (bus.frame_cnt !== 8'd1) begin failures++; $display("FAIL midrst_next_cnt got=%0d want=1", bus.frame_cnt); end
  endtask

  task automatic test_back_to_back_wrap();
    do_reset();
    bus.po_ready = 1'b1;
    for (int i = 0; i < 257; i++) begin
      send_frame(2'd0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 32'($urandom_range(0, 255)), 8, 1'b1);
      if (i == 255) begin
        checks++; if (bus.frame_cnt !== 8'd0) begin failures++; $display("FAIL wrap_cnt got=%0d want=0", bus.frame_cnt); end
      end
    end
    bus.si_valid = 1'b0;
    checks++; if (bus.frame_cnt !== 8'd1) begin failures++; $display("FAIL wrap_after got=%0d want=1", bus.frame_cnt); end
    checks++; if (bus.po_data !== exp_data) begin failures++; $display("FAIL b2b_data got=%h want=%h", bus.po_data, exp_data); end
    checks++; if (bus.po_err !== 1'b0) begin failures++; $display("FAIL b2b_err got=%b want=0", bus.po_err); end
  endtask

  task automatic test_random();
    logic [1:0]  len;
    logic        msb, low, fill;
    logic [31:0] v;
    int          n, gap;
    logic [31:0] keep;
    do_reset();
    for (int i = 0; i < 80; i++) begin
      if (i % 16 == 0) do_reset();
      len  = 2'($urandom_range(0, 3));
      msb  = 1'($urandom_range(0, 1));
      low  = 1'($urandom_range(0, 1));
      fill = 1'($urandom_range(0, 1));
      n    = (int'(len) + 1) * 8;
      v    = $urandom;
      case (len)
        2'd0:    keep = 32'h000000FF;
        2'd1:    keep = 32'h0000FFFF;
        2'd2:    keep = fill ? 32'h00FFFF00 : 32'h0000FFFF;
        default: keep = fill ? 32'hFFFF0000 : 32'h0000FFFF;
      endcase
      if ($urandom_range(0, 3) != 0) v = v & keep;
      gap = $urandom_range(0, 2);
      bus.po_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) begin
        send_frame(len, msb, low, fill, v, $urandom_range(1, n - 1), 1'b1);
        bus.si_valid = 1'b0;
        tick(1'b0, 16'h0, 1'b0, 1'b1);
      end else begin
        send_frame(len, msb, low, fill, v, n, gap == 0);
      end
      checks++; if (bus.po_valid !== exp_valid) begin failures++; $display("FAIL rand_valid[%0d] got=%b want=%b", i, bus.po_valid, exp_valid); end
      checks++; if (exp_valid && bus.po_data !== exp_data) begin failures++; $display("FAIL rand_data[%0d] got=%h want=%h", i, bus.po_data, exp_data); end
      checks++; if (bus.po_err !== exp_err) begin failures++; $display("FAIL rand_err[%0d] got=%b want=%b", i, bus.po_err, exp_err); end
      checks++; if (bus.frame_cnt !== exp_cnt) begin failures++; $display("FAIL rand_cnt[%0d] got=%0d want=%0d", i, bus.frame_cnt, exp_cnt); end
      for (int g = 0; g < gap; g++) begin
        bus.si_valid = 1'b0;
        bus.po_ready = 1'($urandom_range(0, 1));
        tick(1'b0, 16'h0, 1'b0, 1'b0);
      end
    end
    bus.si_valid = 1'b0;
  endtask

  initial begin
    bus.si_data    = 1'b0;
    bus.si_valid   = 1'b0;
    bus.cfg_length = 2'd0;
    bus.cfg_msb    = 1'b0;
    bus.cfg_low    = 1'b0;
    bus.cfg_fill   = 1'b0;
    bus.po_ready   = 1'b1;
    test_reset();
    test_msb8();
    test_lsb16();
    test_pad24();
    test_overflow();
    test_abort();
    test_reset_midframe();
    test_back_to_back_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
